// File: rtl/ram16_drain_ctrl.sv
// ram16_drain_ctrl
// Read-side controller for the 16-bit capture RAM. Waits for RAM_FULL, reads
// addresses 0..DEPTH-1 in order, and streams each word out on a valid/ready
// port. After the last word it pulses RAM_CLR so the writer can refill.
//
// Ports
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   RAM_FULL      RAM full flag, only looked at in IDLE
//   RAM_DO        registered RAM read data, valid the cycle after RAM_EN
//   RAM_EN/RAM_A  read enable and address (this block never writes)
//   RAM_CLR       one-cycle clear pulse at end of frame
//   BUSY          high from frame start through the RAM_CLR cycle
//   OUT_*         streamed word with first/last qualifiers, valid/ready
//   FRAME_CNT     completed frames, wraps 255 -> 0
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for RAM_FULL
// READ    | RAM_EN high for one cycle at addr
// CAPTURE | RAM_DO valid, loaded into the output register
// PRESENT | word offered downstream, held until OUT_READY
// CLEAR   | RAM_CLR high, frame counter advanced, back to IDLE
module ram16_drain_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = (1 << ADDR_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RAM_FULL,
    input  logic [15:0]           RAM_DO,
    output logic                  RAM_EN,
    output logic [ADDR_WIDTH-1:0] RAM_A,
    output logic                  RAM_CLR,
    output logic                  BUSY,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [15:0]           OUT_DATA,
    output logic                  OUT_FIRST,
    output logic                  OUT_LAST,
    output logic [7:0]            FRAME_CNT
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_PRESENT,
        S_CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic                  ram_clr_q, ram_clr_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [15:0]           data_q, data_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_a_q     <= '0;
            ram_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_en_q    <= ram_en_d;
            ram_a_q     <= ram_a_d;
            ram_clr_q   <= ram_clr_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            first_q     <= first_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // RAM_EN and RAM_CLR are computed one state ahead so that, once
    // registered, they are high during exactly the READ and CLEAR cycles.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ram_en_d    = 1'b0;
        ram_a_d     = ram_a_q;
        ram_clr_d   = 1'b0;
        busy_d      = busy_q;
        valid_d     = valid_q;
        data_d      = data_q;
        first_d     = first_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (RAM_FULL) begin
                    state_d  = S_READ;
                    busy_d   = 1'b1;
                    addr_d   = '0;
                    ram_en_d = 1'b1;
                    ram_a_d  = '0;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d  = RAM_DO;
                valid_d = 1'b1;
                first_d = (addr_q == '0);
                last_d  = (addr_q == LAST_ADDR);
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (valid_q && OUT_READY) begin
                    valid_d = 1'b0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        state_d   = S_CLEAR;
                        ram_clr_d = 1'b1;
                    end else begin
                        addr_d   = addr_q + 1'b1;
                        ram_en_d = 1'b1;
                        ram_a_d  = addr_q + 1'b1;
                        state_d  = S_READ;
                    end
                end
            end
            S_CLEAR: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign RAM_EN    = ram_en_q;
    assign RAM_A     = ram_a_q;
    assign RAM_CLR   = ram_clr_q;
    assign BUSY      = busy_q;
    assign OUT_VALID = valid_q;
    assign OUT_DATA  = data_q;
    assign OUT_FIRST = first_q;
    assign OUT_LAST  = last_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_ram16_drain_ctrl.sv
// Testbench for ram16_drain_ctrl: a behavioural RAM with FULL/CLR, a queue of
// expected frames, and a negedge monitor that pops on every accepted word.
module tb_ram16_drain_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RAM_FULL;
    logic [15:0]   RAM_DO;
    logic          RAM_EN;
    logic [AW-1:0] RAM_A;
    logic          RAM_CLR;
    logic          BUSY;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [15:0]   OUT_DATA;
    logic          OUT_FIRST;
    logic          OUT_LAST;
    logic [7:0]    FRAME_CNT;

    ram16_drain_ctrl #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST), .RAM_FULL(RAM_FULL), .RAM_DO(RAM_DO),
        .RAM_EN(RAM_EN), .RAM_A(RAM_A), .RAM_CLR(RAM_CLR), .BUSY(BUSY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_FIRST(OUT_FIRST), .OUT_LAST(OUT_LAST), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [15:0] mem [DEPTH];
    logic        ram_full = 1'b0;
    logic        fill_req = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_clr = 0;

    assign RAM_FULL = ram_full;

    // Behavioural RAM: registered read port, FULL set by the writer and
    // dropped on the edge that sees RAM_CLR.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RAM_EN) RAM_DO <= mem[RAM_A];
        if (RAM_CLR) ram_full <= 1'b0;
        else if (fill_req) ram_full <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream for one frame: every location in address order.
    task automatic push_frame();
        for (int i = 0; i < DEPTH; i++) begin
            word_t w;
            w.data  = mem[i];
            w.first = (i == 0);
            w.last  = (i == DEPTH - 1);
            exp_q.push_back(w);
        end
    endtask

    // Monitor
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    always @(negedge CLK) begin
        if (RST) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", OUT_VALID, 1);
                check("stall_data_held", OUT_DATA, prev_data);
                check("stall_ram_en_low", RAM_EN, 0);
            end
            if (RAM_CLR) n_clr <= n_clr + 1;
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", OUT_DATA, w.data);
                    check("word_first", OUT_FIRST, w.first);
                    check("word_last", OUT_LAST, w.last);
                end
                n_acc <= n_acc + 1;
            end
            prev_stall <= OUT_VALID && !OUT_READY;
            prev_data  <= OUT_DATA;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    endtask

    // Signal FULL, wait for the frame to start and finish; returns the number
    // of post-edge samples on which BUSY was high.
    task automatic run_frame(input bit rand_ready, output int busy_cycles);
        int k;
        fill_req = 1'b1;
        @(posedge CLK); #1;
        fill_req = 1'b0;
        for (k = 0; k < 5 && !BUSY; k++) begin
            @(posedge CLK); #1;
        end
        check("busy_rise_in_time", BUSY, 1);
        busy_cycles = 0;
        while (BUSY && busy_cycles < 5000) begin
            busy_cycles++;
            if (rand_ready) OUT_READY = ($urandom_range(3) != 0);
            @(posedge CLK); #1;
        end
        check("busy_fall_in_time", BUSY, 0);
        OUT_READY = 1'b1;
    endtask

    initial begin
        int k;
        int t0;
        int acc_base;
        int clr_base;
        int bc;
        bit busy_seen;

        RST       = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 3);
        push_frame();
        fill_req  = 1'b1;

        // Reset with FULL already asserted.
        @(posedge CLK); #1;
        fill_req = 1'b0;
        check("rst_ram_en_c1", RAM_EN, 0);
        @(posedge CLK); #1;
        check("rst_ram_en_c2", RAM_EN, 0);
        check("rst_ram_a", RAM_A, 0);
        check("rst_ram_clr", RAM_CLR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_out_first", OUT_FIRST, 0);
        check("rst_out_last", OUT_LAST, 0);
        check("rst_frame_cnt", FRAME_CNT, 0);
        RST = 1'b0;

        // First IDLE cycle with FULL seen -> OUT_VALID three cycles later.
        @(negedge CLK);
        t0 = cyc;
        for (k = 0; k < 10 && !OUT_VALID; k++) @(negedge CLK);
        check("first_valid_latency", cyc - t0, 3);

        // Reset in the middle of the frame, at word 10.
        for (k = 0; k < 1000 && n_acc < 10; k++) begin
            @(posedge CLK); #1;
        end
        check("reached_word10", n_acc, 10);
        clr_base = n_clr;
        RST = 1'b1;
        exp_q.delete();
        push_frame();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("midrst_busy", BUSY, 0);
        check("midrst_valid", OUT_VALID, 0);
        check("midrst_frame_cnt", FRAME_CNT, 0);
        check("midrst_no_clr", n_clr, clr_base);
        acc_base = n_acc;
        RST = 1'b0;

        // Frame restarts from address 0 (FULL still high); stall word 5.
        for (k = 0; k < 1000 && (n_acc - acc_base) < 5; k++) begin
            @(posedge CLK); #1;
        end
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
        end
        check("stall_word5_valid", OUT_VALID, 1);
        check("stall_word5_data", OUT_DATA, 15);
        OUT_READY = 1'b1;
        for (k = 0; k < 1000 && BUSY; k++) begin
            @(posedge CLK); #1;
        end
        check("frame1_done", BUSY, 0);
        check("frame1_cnt", FRAME_CNT, 1);
        check("frame1_clr_pulses", n_clr - clr_base, 1);
        check("frame1_all_words", exp_q.size(), 0);

        // FULL held through CLEAR must not start another frame.
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (BUSY) busy_seen = 1'b1;
            @(posedge CLK); #1;
        end
        check("no_stale_rearm", busy_seen, 0);

        // Re-arm with ready held high: frame span is 3*DEPTH+2 edges.
        fill_random();
        push_frame();
        run_frame(1'b0, bc);
        check("frame2_span", bc + 1, 3 * DEPTH + 2);
        check("frame2_cnt", FRAME_CNT, 2);
        check("frame2_all_words", exp_q.size(), 0);

        // Random data and backpressure until the counter wraps.
        for (int f = 3; f <= 256; f++) begin
            fill_random();
            push_frame();
            run_frame(1'b1, bc);
            check("frame_cnt", FRAME_CNT, 32'(f % 256));
        end
        check("wrap_frame_cnt_zero", FRAME_CNT, 0);
        check("total_clr_pulses", n_clr - clr_base, 256);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
